// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 11
);
  logic [7:0]        w_rx_data;
  logic              w_rx_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [31:0]       r_din;

  modport master (
    input  w_rx_data, w_rx_valid,
    output r_addr, r_we, r_din
  );

  modport slave (
    output w_rx_data, w_rx_valid,
    input  r_addr, r_we, r_din
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a SYNC/length/data/XOR-checksum framed byte stream into instruction memory
// and holds the CPU in reset until a complete image has been verified.
module imem_loader #(
  parameter int unsigned ADDR_W  = 11,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic          w_clk,
  input  logic          w_rst,
  imem_loader_if.master bus,
  output logic          r_cpu_rst,
  output logic          r_busy,
  output logic          r_done,
  output logic          r_err
);

  localparam int unsigned LW = ADDR_W + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] MAXN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {HUNT, LEN1, LEN2, DATA, CSUM, ERR} state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [LW-1:0]     len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       din_q, din_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [LW-1:0] n_w;
  logic          fail;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q   <= HUNT;
      len_hi_q  <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      asm_q     <= '0;
      bcnt_q    <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      din_q     <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      asm_q     <= asm_d;
      bcnt_q    <= bcnt_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      din_q     <= din_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    len_d     = len_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    asm_d     = asm_q;
    bcnt_d    = bcnt_q;
    tmo_d     = '0;
    addr_d    = addr_q;
    we_d      = 1'b0;
    din_d     = din_q;
    cpu_rst_d = cpu_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    fail      = 1'b0;
    n_w       = LW'({len_hi_q, bus.w_rx_data});

    case (state_q)
      HUNT: begin
        if (bus.w_rx_valid && bus.w_rx_data == SYNC) begin
          cpu_rst_d = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          idx_d     = '0;
          csum_d    = '0;
          bcnt_d    = '0;
          state_d   = LEN1;
        end
      end
      ERR: state_d = HUNT;
      default: begin
        // Every in-frame state shares the inter-byte timeout; a byte always restarts it.
        if (!bus.w_rx_valid) begin
          if (tmo_q == TMAX) fail = 1'b1;
          else               tmo_d = tmo_q + 1'b1;
        end else begin
          case (state_q)
            LEN1: begin
              len_hi_d = bus.w_rx_data;
              state_d  = LEN2;
            end
            LEN2: begin
              len_d = n_w;
              if (n_w == '0 || n_w > MAXN) fail = 1'b1;
              else                         state_d = DATA;
            end
            DATA: begin
              asm_d  = {asm_q[15:0], bus.w_rx_data};
              csum_d = csum_q ^ bus.w_rx_data;
              bcnt_d = bcnt_q + 1'b1;
              if (bcnt_q == 2'd3) begin
                we_d   = 1'b1;
                addr_d = idx_q;
                din_d  = {asm_q, bus.w_rx_data};
                idx_d  = idx_q + 1'b1;
                if ({1'b0, idx_q} == len_q - 1'b1) state_d = CSUM;
              end
            end
            CSUM: begin
              if (bus.w_rx_data == csum_q) begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                cpu_rst_d = 1'b0;
                state_d   = HUNT;
              end else begin
                fail = 1'b1;
              end
            end
            default: state_d = HUNT;
          endcase
        end
      end
    endcase

    if (fail) begin
      state_d = ERR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
    end
  end

  assign bus.r_addr = addr_q;
  assign bus.r_we   = we_q;
  assign bus.r_din  = din_q;
  assign r_cpu_rst  = cpu_rst_q;
  assign r_busy     = busy_q;
  assign r_done     = done_q;
  assign r_err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and frame outcomes are queued
// by the stimulus and popped by an independent monitor.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 11;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_rst, busy, done, err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5), .TIMEOUT(16)) dut (
    .w_clk     (clk),
    .w_rst     (rst),
    .bus       (bus.master),
    .r_cpu_rst (cpu_rst),
    .r_busy    (busy),
    .r_done    (done),
    .r_err     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t        wq[$];
  logic [3:0] oq[$];
  logic [7:0] txq[$];
  logic       done_prev, err_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse and every rising done/err is matched against the queues.
  always @(negedge clk) begin
    if (rst) begin
      done_prev <= 1'b0;
      err_prev  <= 1'b0;
    end else begin
      if (bus.r_we) begin
        if (wq.size() == 0) begin
          check("unexpected_write", {21'd0, bus.r_addr, bus.r_din}, 64'd0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("write_addr", {53'd0, bus.r_addr}, {53'd0, w.addr});
          check("write_data", {32'd0, bus.r_din}, {32'd0, w.data});
        end
      end
      if ((done && !done_prev) || (err && !err_prev)) begin
        if (oq.size() == 0) begin
          check("unexpected_outcome", {60'd0, cpu_rst, busy, done, err}, 64'd0);
        end else begin
          logic [3:0] o;
          o = oq.pop_front();
          check("outcome", {60'd0, cpu_rst, busy, done, err}, {60'd0, o});
        end
      end
      done_prev <= done;
      err_prev  <= err;
    end
  end

  // Called at a negedge; leaves the bus idle at the next negedge plus 'gap' idle cycles per byte.
  task automatic send_txq(input int gap);
    while (txq.size() != 0) begin
      bus.w_rx_data  = txq.pop_front();
      bus.w_rx_valid = 1'b1;
      @(negedge clk);
      bus.w_rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && (oq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
    check(name, {32'(oq.size()), 32'(wq.size())}, 64'd0);
  endtask

  localparam logic [3:0] OK  = 4'b0010;  // {cpu_rst, busy, done, err}
  localparam logic [3:0] BAD = 4'b1001;

  initial begin
    bus.w_rx_data  = 8'h00;
    bus.w_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr",    {53'd0, bus.r_addr}, 64'd0);
    check("rst_we",      {63'd0, bus.r_we}, 64'd0);
    check("rst_din",     {32'd0, bus.r_din}, 64'd0);
    check("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    check("rst_busy",    {63'd0, busy}, 64'd0);
    check("rst_done",    {63'd0, done}, 64'd0);
    check("rst_err",     {63'd0, err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good load; XOR of data bytes = 0x96.
    wq.push_back('{11'd0, 32'h20010005});
    wq.push_back('{11'd1, 32'hAC1E0000});
    oq.push_back(OK);
    txq = {8'hA5};
    send_txq(0);
    check("busy_in_frame", {62'd0, cpu_rst, busy}, 64'd3);
    txq = {8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h1E, 8'h00, 8'h00, 8'h96};
    send_txq(0);
    drain("good_drain", 20);

    // Noise while done is ignored; SYNC restarts a load on the next cycle.
    txq = {8'h00, 8'hFF};
    send_txq(0);
    check("noise_status", {60'd0, cpu_rst, busy, done, err}, {60'd0, OK});
    wq.push_back('{11'd0, 32'h20010005});
    wq.push_back('{11'd1, 32'hAC1E0000});
    oq.push_back(BAD);
    txq = {8'hA5};
    send_txq(0);
    check("reload_status", {61'd0, cpu_rst, done, err}, 64'b100);
    txq = {8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h1E, 8'h00, 8'h00, 8'h00};
    send_txq(0);
    drain("badcsum_drain", 20);

    wq.push_back('{11'd0, 32'h20010005});
    wq.push_back('{11'd1, 32'hAC1E0000});
    oq.push_back(OK);
    txq = {8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h1E, 8'h00, 8'h00, 8'h96};
    send_txq(0);
    drain("recover_drain", 20);

    // Invalid lengths: zero and 2049 words.
    oq.push_back(BAD);
    txq = {8'hA5, 8'h00, 8'h00};
    send_txq(0);
    drain("len0_drain", 10);
    oq.push_back(BAD);
    txq = {8'hA5, 8'h08, 8'h01};
    send_txq(0);
    drain("lenmax_drain", 10);

    // Timeout mid-word, then non-SYNC bytes are ignored.
    oq.push_back(BAD);
    txq = {8'hA5, 8'h00, 8'h01, 8'h20, 8'h01};
    send_txq(0);
    drain("timeout_drain", 40);
    txq = {8'h11, 8'h22};
    send_txq(2);
    check("timeout_hunt", {60'd0, cpu_rst, busy, done, err}, {60'd0, BAD});

    // Byte gaps of TIMEOUT-1 cycles are still accepted; checksum DE^AD^BE^EF = 0x22.
    wq.push_back('{11'd0, 32'hDEADBEEF});
    oq.push_back(OK);
    txq = {8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_txq(14);
    drain("slow_drain", 40);

    // Asynchronous reset after 6 data bytes.
    wq.push_back('{11'd0, 32'h11223344});
    txq = {8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_txq(0);
    rst = 1'b1;
    #1;
    check("midrst_addr",   {53'd0, bus.r_addr}, 64'd0);
    check("midrst_din",    {32'd0, bus.r_din}, 64'd0);
    check("midrst_status", {59'd0, bus.r_we, cpu_rst, busy, done, err}, 64'b01000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wq.push_back('{11'd0, 32'h20010005});
    wq.push_back('{11'd1, 32'hAC1E0000});
    oq.push_back(OK);
    txq = {8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h1E, 8'h00, 8'h00, 8'h96};
    send_txq(0);
    drain("postrst_drain", 20);
    check("final_status", {60'd0, cpu_rst, busy, done, err}, {60'd0, OK});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
